// File: rtl/fft_sched_pkg.sv
// Shared types and width helpers for the FFT frame scheduler.
package fft_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREP,
    ST_BURST,
    ST_GAP
  } sched_state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int sample_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample buffer: one write port, one registered read port.
module fft_pingpong_ram #(
  parameter int AW = 4,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [SW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [SW-1:0] rd_data
);

  logic [SW-1:0] mem [2**AW];

  // The array is deliberately not reset; full flags decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_sched.sv
// Buffers N-sample I/Q frames in ping-pong banks and replays each one to the
// FFT core as a contiguous enable burst followed by a fixed idle gap.
module fft_frame_sched
  import fft_sched_pkg::*;
#(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 8,
  parameter int GAP        = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_i,
  input  logic [DATA_WIDTH-1:0] s_q,
  output logic                  fft_enable,
  output logic [DATA_WIDTH-1:0] fft_i_in,
  output logic [DATA_WIDTH-1:0] fft_q_in,
  output logic                  fft_sof,
  output logic [15:0]           frame_cnt,
  output logic                  busy
);

  localparam int PW = ptr_width(N);
  localparam int SW = sample_width(DATA_WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [PW-1:0] LAST    = PW'(N - 1);
  localparam logic [GW-1:0] GAP_END = GW'(GAP - 1);

  sched_state_t  state, state_nx;
  logic [1:0]    full, full_set, full_clr;
  logic          wr_bank, rd_bank;
  logic [PW-1:0] wr_ptr, k_cnt, rd_ptr;
  logic [GW-1:0] gap_cnt;
  logic          wr_fire, wr_last, rd_done;
  logic [SW-1:0] rd_data;

  assign s_ready  = run & ~full[wr_bank];
  assign wr_fire  = s_valid & s_ready;
  assign wr_last  = wr_fire && (wr_ptr == LAST);
  assign rd_done  = (state == ST_BURST) && (k_cnt == LAST);
  assign full_set = wr_last ? (2'b01 << wr_bank) : 2'b00;
  assign full_clr = rd_done ? (2'b01 << rd_bank) : 2'b00;

  // Address runs one ahead of the presented sample to hide the read latency.
  assign rd_ptr = (state == ST_BURST) ? k_cnt + PW'(1) : '0;

  fft_pingpong_ram #(
    .AW(PW + 1),
    .SW(SW)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_fire),
    .wr_addr({wr_bank, wr_ptr}),
    .wr_data({s_i, s_q}),
    .rd_addr({rd_bank, rd_ptr}),
    .rd_data(rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
    end else if (!run) begin
      wr_ptr <= '0;
    end else if (wr_fire) begin
      if (wr_last) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr <= wr_ptr + PW'(1);
      end
    end
  end

  // Set and clear always target different banks, so both apply together.
  always_ff @(posedge clk) begin
    if (!rst_n) full <= '0;
    else        full <= (full & ~full_clr) | full_set;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (full[rd_bank]) state_nx = ST_PREP;
      ST_PREP:  state_nx = ST_BURST;
      ST_BURST: if (k_cnt == LAST) state_nx = ST_GAP;
      ST_GAP:   if (gap_cnt == GAP_END) state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_cnt      <= '0;
      gap_cnt    <= '0;
      rd_bank    <= 1'b0;
      frame_cnt  <= '0;
      fft_enable <= 1'b0;
      fft_sof    <= 1'b0;
    end else begin
      fft_enable <= (state_nx == ST_BURST);
      fft_sof    <= (state == ST_PREP);
      k_cnt      <= (state == ST_BURST) ? k_cnt + PW'(1) : '0;
      gap_cnt    <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
      if (rd_done) begin
        rd_bank   <= ~rd_bank;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  assign fft_i_in = fft_enable ? rd_data[SW-1 -: DATA_WIDTH] : '0;
  assign fft_q_in = fft_enable ? rd_data[DATA_WIDTH-1:0] : '0;
  assign busy     = (|full) | fft_enable;

endmodule

// File: tb/tb_fft_frame_sched.sv
// Self-checking bench for fft_frame_sched: frame-level reference model plus
// directed scenarios with hand-computed expectations.
module tb_fft_frame_sched;

  localparam int N   = 8;
  localparam int DW  = 8;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_i = '0;
  logic [DW-1:0] s_q = '0;
  logic          s_ready, fft_enable, fft_sof, busy;
  logic [DW-1:0] fft_i_in, fft_q_in;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  fft_frame_sched #(.N(N), .DATA_WIDTH(DW), .GAP(GAP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_i       (s_i),
    .s_q       (s_q),
    .fft_enable(fft_enable),
    .fft_i_in  (fft_i_in),
    .fft_q_in  (fft_q_in),
    .fft_sof   (fft_sof),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: each completed frame gets a burst start edge, its
  // release edge is start+N, and bursts are spaced by at least N+GAP+2.
  int          fr_s[$];
  int          fr_r[$];
  logic [15:0] fr_data[$];
  logic [15:0] part[$];
  logic [15:0] m_cnt = '0;
  int          last_s = -1000;

  int          sof_cyc[$];
  logic [7:0]  sof_i[$];
  int          run_len = 0;
  int          last_run = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int  ns;
    bit  ready_m;
    cyc = cyc + 1;
    if (!rst_n) begin
      fr_s.delete();
      fr_r.delete();
      fr_data.delete();
      part.delete();
      m_cnt  = '0;
      last_s = -1000;
    end else begin
      ready_m = run && (fr_s.size() < 2);
      while (fr_s.size() > 0 && fr_r[0] == cyc) begin
        void'(fr_s.pop_front());
        void'(fr_r.pop_front());
        for (int j = 0; j < N; j++) void'(fr_data.pop_front());
        m_cnt = m_cnt + 16'd1;
      end
      if (!run) begin
        part.delete();
      end else if (s_valid && ready_m) begin
        part.push_back({s_i, s_q});
        if (part.size() == N) begin
          ns = (cyc + 2 > last_s + N + GAP + 2) ? cyc + 2 : last_s + N + GAP + 2;
          fr_s.push_back(ns);
          fr_r.push_back(ns + N);
          foreach (part[j]) fr_data.push_back(part[j]);
          part.delete();
          last_s = ns;
        end
      end
    end
  end

  always @(negedge clk) begin
    bit          exp_en;
    int          k;
    logic [15:0] exp_d;
    if (chk_en) begin
      exp_en = (fr_s.size() > 0) && (fr_s[0] <= cyc);
      k      = exp_en ? cyc - fr_s[0] : 0;
      exp_d  = exp_en ? fr_data[k] : 16'h0000;
      checkOutput("fft_enable", 32'(fft_enable), 32'(exp_en));
      checkOutput("fft_sof", 32'(fft_sof), 32'(exp_en && k == 0));
      checkOutput("fft_i_in", 32'(fft_i_in), 32'(exp_d[15:8]));
      checkOutput("fft_q_in", 32'(fft_q_in), 32'(exp_d[7:0]));
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      checkOutput("busy", 32'(busy), 32'(fr_s.size() > 0));
      checkOutput("s_ready", 32'(s_ready), 32'(run && fr_s.size() < 2));
    end
    if (fft_enable === 1'b1) begin
      run_len++;
      if (fft_sof === 1'b1) begin
        sof_cyc.push_back(cyc);
        sof_i.push_back(fft_i_in);
      end
    end else if (run_len > 0) begin
      last_run = run_len;
      run_len  = 0;
    end
  end

  // Called and returns at #1 after a rising edge; spacing>1 gives sparse input.
  task automatic applyStimulus(input int cnt, input logic [7:0] bi, input logic [7:0] bq,
                               input int spacing, output int last_edge, output int stalls);
    int n = 0;
    int guard = 0;
    bit acc;
    stalls = 0;
    last_edge = 0;
    while (n < cnt && guard < 1000) begin
      s_valid = 1'b1;
      s_i = 8'(bi + n);
      s_q = 8'(bq + n);
      acc = s_ready;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        n++;
        last_edge = cyc;
        if (spacing > 1) begin
          s_valid = 1'b0;
          repeat (spacing - 1) begin
            @(posedge clk);
            #1;
          end
        end
      end else begin
        stalls++;
      end
    end
    s_valid = 1'b0;
    if (n < cnt) checkOutput("stim_timeout", 32'(n), 32'(cnt));
  endtask

  task automatic waitIdle();
    int guard = 0;
    @(negedge clk);
    while ((busy !== 1'b0 || fft_enable !== 1'b0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) checkOutput("drain_timeout", 32'(busy), 32'(0));
    repeat (GAP + 2) @(posedge clk);
    #1;
  endtask

  task automatic waitSof(output int at);
    int guard = 0;
    at = -1;
    while (guard < 100) begin
      @(negedge clk);
      if (fft_enable === 1'b1) begin
        at = cyc;
        break;
      end
      guard++;
    end
    if (at < 0) checkOutput("sof_timeout", 32'(fft_enable), 32'(1));
  endtask

  initial begin
    int a_edge, stalls, rise;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    checkOutput("rst_enable", 32'(fft_enable), 32'(0));
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_ready_norun", 32'(s_ready), 32'(0));
    @(posedge clk);
    #1 run = 1'b1;
    @(negedge clk);
    checkOutput("ready_with_run", 32'(s_ready), 32'(1));
    @(posedge clk);
    #1;

    $display("[TB] single frame");
    applyStimulus(8, 8'h01, 8'h10, 1, a_edge, stalls);
    waitSof(rise);
    checkOutput("single_latency", 32'(rise - a_edge), 32'(2));
    checkOutput("single_first_i", 32'(fft_i_in), 32'(8'h01));
    checkOutput("single_first_q", 32'(fft_q_in), 32'(8'h10));
    checkOutput("single_sof", 32'(fft_sof), 32'(1));
    waitIdle();
    checkOutput("single_cnt", 32'(frame_cnt), 32'(1));
    checkOutput("single_len", 32'(last_run), 32'(N));

    $display("[TB] back-to-back stream");
    applyStimulus(40, 8'h20, 8'h30, 1, a_edge, stalls);
    checkOutput("b2b_stalled", 32'(stalls > 0), 32'(1));
    waitIdle();
    checkOutput("b2b_cnt", 32'(frame_cnt), 32'(6));
    checkOutput("b2b_period", 32'(sof_cyc[$] - sof_cyc[$-1]), 32'(N + GAP + 2));
    checkOutput("b2b_last_first_i", 32'(sof_i[$]), 32'(8'h40));

    $display("[TB] partial frame drop");
    applyStimulus(5, 8'h70, 8'h71, 1, a_edge, stalls);
    run = 1'b0;
    @(posedge clk);
    #1 run = 1'b1;
    applyStimulus(8, 8'h50, 8'h58, 1, a_edge, stalls);
    waitIdle();
    checkOutput("drop_first_i", 32'(sof_i[$]), 32'(8'h50));
    checkOutput("drop_cnt", 32'(frame_cnt), 32'(7));

    $display("[TB] reset mid-burst");
    applyStimulus(8, 8'h60, 8'h68, 1, a_edge, stalls);
    waitSof(rise);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_enable", 32'(fft_enable), 32'(0));
    checkOutput("midrst_cnt", 32'(frame_cnt), 32'(0));
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_ready", 32'(s_ready), 32'(1));
    rst_n = 1'b1;
    applyStimulus(8, 8'h11, 8'h22, 1, a_edge, stalls);
    waitIdle();
    checkOutput("midrst_recover_cnt", 32'(frame_cnt), 32'(1));
    checkOutput("midrst_recover_i", 32'(sof_i[$]), 32'(8'h11));

    $display("[TB] frame counter wrap");
    force dut.frame_cnt = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1 release dut.frame_cnt;
    @(posedge clk);
    #1;
    applyStimulus(8, 8'hA0, 8'hB0, 1, a_edge, stalls);
    waitIdle();
    checkOutput("wrap_cnt", 32'(frame_cnt), 32'(0));

    $display("[TB] sparse input");
    applyStimulus(8, 8'h80, 8'h90, 3, a_edge, stalls);
    waitIdle();
    checkOutput("sparse_len", 32'(last_run), 32'(N));
    checkOutput("sparse_cnt", 32'(frame_cnt), 32'(1));
    checkOutput("sparse_first_i", 32'(sof_i[$]), 32'(8'h80));

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    total++;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
